rf_wb_arbiter: RTL

Owns the single register-file write port (A3/WE3/WD3) and shares it between two writeback requesters: port 0 for the ALU result and port 1 for load data. After reset it first runs a clear sequence that writes zero to x1..x31. It then arbitrates requests round-robin, drops writes to x0 and drives registered write controls into the register file. It also flags read addresses whose write is still in flight, so the core can forward the data.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_rr_arbiter2.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the FSM encoding, the register-file geometry constants and the default widths.
package rf_wb_arbiter_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_ZERO  = 0;
  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin grant with its pointer flop.
// The pointer only moves when both inputs contend, so a lone requester never disturbs fairness.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (en && (&valid)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: zero sweep after reset, then round-robin writeback
// from the ALU and load ports, with registered write controls and in-flight hazard flags.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rd1_pend,
  output logic          rd2_pend,
  output logic [DW-1:0] fwd_data,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST_REG = AW'(REG_COUNT - 1);
  localparam logic [AW-1:0] ZERO_REG = AW'(REG_ZERO);

  wb_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          we_d, done_d;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;
  logic [1:0]    grant;
  logic          rr_ptr;
  logic          in_run;

  assign in_run = (state_q == ST_RUN);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run),
    .valid ({req1_valid, req0_valid}),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    done_d  = init_done;
    if (state_q == ST_INIT) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = '0;
      cnt_d   = cnt_q + AW'(1);
      if (cnt_q == LAST_REG) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
    end else if (grant[0]) begin
      we_d    = (req0_addr != ZERO_REG);
      waddr_d = req0_addr;
      wdata_d = req0_data;
    end else if (grant[1]) begin
      we_d    = (req1_addr != ZERO_REG);
      waddr_d = req1_addr;
      wdata_d = req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT_CLEAR ? ST_INIT : ST_RUN;
      cnt_q     <= AW'(1);
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= ~INIT_CLEAR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_we     <= we_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
      init_done <= done_d;
    end
  end

  // Sweep writes are not real data hazards, so the flags stay quiet until RUN.
  assign rd1_pend = in_run & rf_we & (rf_waddr == raddr1) & (raddr1 != ZERO_REG);
  assign rd2_pend = in_run & rf_we & (rf_waddr == raddr2) & (raddr2 != ZERO_REG);
  assign fwd_data = rf_wdata;

endmodule
